float_to_uint_arbiter: RTL and testbench

Shares one float-to-unsigned-integer conversion datapath between `NUM_REQ` requesters, such as shading, traversal and framebuffer address units. It uses round-robin arbitration and valid/ready handshakes on both sides. The conversion is a two-stage pipeline with full backpressure. It also sanitises out-of-range inputs: negative, fractional-only, overflow, Inf and NaN values get a defined result and a flag.

---
 rtl/float_to_uint_arbiter.sv | 123 ++++++++++++
 tb/tb_float_to_uint_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/float_to_uint_arbiter.sv
// Round-robin shared float-to-uint converter: NUM_REQ requesters feed a
// two-stage pipeline (A: operand, B: result) with full valid/ready backpressure.

module float_to_uint (
  input  logic [31:0] f,
  output logic [23:0] u
);
  logic [7:0] sh;

  // Valid only for 127 <= E <= 150; the caller overrides everything else.
  assign sh = 8'd150 - f[30:23];
  assign u  = {1'b1, f[22:0]} >> sh;
endmodule

module float_to_uint_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_float,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [23:0]             resp_uint,
  output logic [2:0]              resp_flags,
  output logic                    busy,
  output logic [15:0]             conv_count
);
  localparam logic [2:0] FL_NEG = 3'b100, FL_UNDER = 3'b010, FL_OVF = 3'b001;

  logic [ID_W-1:0]    rr_ptr, win_id;
  logic [NUM_REQ-1:0] grant;
  logic               found, accept, a_free, b_free;
  logic [31:0]        win_float;
  int                 idx;

  logic               a_valid;
  logic [ID_W-1:0]    a_id;
  logic [31:0]        a_float;

  logic [23:0]        cvt_u, c_u;
  logic [2:0]         c_flags;
  logic [7:0]         e;

  // Grant looks only at req_valid and the pointer, so it is stable while
  // a requester waits for the pipeline to free up.
  always_comb begin
    grant  = '0;
    win_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        win_id      = ID_W'(idx);
      end
    end
  end

  assign b_free    = !resp_valid || resp_ready;
  assign a_free    = !a_valid || b_free;
  assign req_ready = rst ? '0 : (grant & {NUM_REQ{a_free}});
  assign accept    = |(req_valid & req_ready);
  assign win_float = req_float[32*int'(win_id) +: 32];
  assign busy      = a_valid || resp_valid;

  float_to_uint u_conv (.f(a_float), .u(cvt_u));

  always_comb begin
    e       = a_float[30:23];
    c_u     = cvt_u;
    c_flags = 3'b000;
    if (a_float[30:0] == 31'd0) begin
      c_u = 24'd0;
    end else if (a_float[31]) begin
      c_u     = 24'd0;
      c_flags = FL_NEG;
    end else if (e < 8'd127) begin
      c_u     = 24'd0;
      c_flags = FL_UNDER;
    end else if (e > 8'd150) begin
      c_u     = 24'hFFFFFF;
      c_flags = FL_OVF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      a_valid    <= 1'b0;
      a_id       <= '0;
      a_float    <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_uint  <= '0;
      resp_flags <= '0;
      conv_count <= '0;
    end else begin
      if (accept) begin
        a_valid <= 1'b1;
        a_id    <= win_id;
        a_float <= win_float;
        rr_ptr  <= (int'(win_id) == NUM_REQ-1) ? '0 : win_id + 1'b1;
      end else if (b_free) begin
        a_valid <= 1'b0;
      end
      if (b_free) begin
        resp_valid <= a_valid;
        if (a_valid) begin
          resp_id    <= a_id;
          resp_uint  <= c_u;
          resp_flags <= c_flags;
        end
      end
      if (resp_valid && resp_ready) conv_count <= conv_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_float_to_uint_arbiter.sv
// Directed bench for float_to_uint_arbiter: reset, latency, round robin,
// backpressure, conversion boundaries and mid-flight reset.

module tb_float_to_uint_arbiter;
  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req_valid;
  logic [3:0][31:0] rf;
  logic [3:0]      req_ready;
  logic            resp_valid, resp_ready, busy;
  logic [1:0]      resp_id;
  logic [23:0]     resp_uint;
  logic [2:0]      resp_flags;
  logic [15:0]     conv_count;

  int checks = 0;
  int errors = 0;

  float_to_uint_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_float(rf),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_uint(resp_uint), .resp_flags(resp_flags),
    .busy(busy), .conv_count(conv_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request from requester id; result visible two edges after acceptance.
  task automatic send_one(input int id, input logic [31:0] f,
                          input logic [23:0] eu, input logic [2:0] ef);
    @(negedge clk);
    rf[id] = f; req_valid[id] = 1'b1; resp_ready = 1'b1;
    #1 chk("one_rdy", 32'(req_ready), 32'(1 << id));
    @(negedge clk);
    req_valid[id] = 1'b0;
    chk("one_busy", 32'(busy), 32'd1);
    chk("one_early", 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk("one_vld", 32'(resp_valid), 32'd1);
    chk("one_id", 32'(resp_id), 32'(id));
    chk("one_uint", 32'(resp_uint), 32'(eu));
    chk("one_flags", 32'(resp_flags), 32'(ef));
  endtask

  logic [1:0]  rr_ids  [6];
  logic [23:0] rr_vals [6];
  logic [31:0] bp_f    [4];
  logic [23:0] bp_u    [4];
  logic [1:0]  bp_id   [4];
  int got, n, stall_acc;
  logic fire;

  initial begin
    rst = 1'b1; req_valid = 4'hF; resp_ready = 1'b0; rf = '0;
    repeat (2) @(negedge clk);
    chk("rst_rdy", 32'(req_ready), 32'd0);
    chk("rst_vld", 32'(resp_valid), 32'd0);
    chk("rst_id", 32'(resp_id), 32'd0);
    chk("rst_uint", 32'(resp_uint), 32'd0);
    chk("rst_flags", 32'(resp_flags), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(conv_count), 32'd0);
    req_valid = 4'h0; rst = 1'b0;

    send_one(1, 32'h42280000, 24'd42, 3'b000);
    send_one(1, 32'h4996B438, 24'd1234567, 3'b000);
    send_one(3, 32'h4B7FFFFF, 24'd16777215, 3'b000);
    send_one(3, 32'h4B800000, 24'hFFFFFF, 3'b001);
    send_one(3, 32'h7FC00000, 24'hFFFFFF, 3'b001);
    send_one(3, 32'h3F000000, 24'd0, 3'b010);
    send_one(3, 32'h3F800000, 24'd1, 3'b000);
    send_one(3, 32'hC2280000, 24'd0, 3'b100);
    send_one(3, 32'h80000000, 24'd0, 3'b000);

    // Round robin: pointer is back at 0 after the last requester-3 grant.
    @(negedge clk);
    rf[0] = 32'h3F800000; rf[1] = 32'h40000000;
    rf[2] = 32'h40400000; rf[3] = 32'h40800000;
    req_valid = 4'hF; resp_ready = 1'b1;
    got = 0;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      if (resp_valid && got < 6) begin
        rr_ids[got] = resp_id; rr_vals[got] = resp_uint; got++;
      end
    end
    chk("rr_count", 32'(got), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk("rr_id", 32'(rr_ids[i]), 32'(i % 4));
      chk("rr_uint", 32'(rr_vals[i]), 32'((i % 4) + 1));
    end
    // Seven grants so far (0,1,2,3,0,1,2): pointer sits at 3.
    req_valid = 4'b0100;
    #1 chk("rr_wrap", 32'(req_ready), 32'b0100);
    @(negedge clk);
    req_valid = 4'h0;
    for (int i = 0; i < 10 && busy; i++) @(negedge clk);
    chk("rr_drain", 32'(busy), 32'd0);

    // Backpressure on a fresh counter.
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    bp_f[0] = 32'h41200000; bp_f[1] = 32'h41A00000;
    bp_f[2] = 32'h41F00000; bp_f[3] = 32'h42200000;
    n = 0; got = 0; fire = 1'b0; stall_acc = 0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      @(negedge clk);
      if (fire) n++;
      req_valid[0] = (n < 4);
      rf[0] = bp_f[n < 4 ? n : 3];
      resp_ready = !(cyc >= 2 && cyc <= 4);
      #1;
      fire = req_valid[0] && req_ready[0];
      if (resp_valid && resp_ready) begin
        bp_u[got] = resp_uint; bp_id[got] = resp_id; got++;
      end
      if (cyc >= 2 && cyc <= 4) begin
        chk("bp_hold", 32'(resp_uint), 32'd10);
        if (fire) stall_acc++;
      end
      if (cyc == 4) chk("bp_rdy0", 32'(req_ready), 32'd0);
    end
    chk("bp_extra", 32'(stall_acc <= 1), 32'd1);
    chk("bp_got", 32'(got), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("bp_uint", 32'(bp_u[i]), 32'((i + 1) * 10));
      chk("bp_id", 32'(bp_id[i]), 32'd0);
    end
    @(negedge clk);
    req_valid = 4'h0;
    chk("bp_cnt", 32'(conv_count), 32'd4);

    // Reset with both stages full.
    @(negedge clk);
    rf[1] = 32'h42280000; req_valid = 4'b0010; resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("mf_busy", 32'(busy), 32'd1);
    chk("mf_full", 32'(resp_valid), 32'd1);
    req_valid = 4'h0; rst = 1'b1;
    @(negedge clk);
    chk("mf_vld", 32'(resp_valid), 32'd0);
    chk("mf_busy0", 32'(busy), 32'd0);
    chk("mf_cnt", 32'(conv_count), 32'd0);
    rst = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    chk("mf_quiet", 32'(resp_valid), 32'd0);
    req_valid = 4'hF;
    #1 chk("mf_grant0", 32'(req_ready), 32'b0001);
    @(negedge clk);
    req_valid = 4'h0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
